// File: rtl/chime_indicator_arbiter.sv
// chime_indicator_arbiter
// Shares the single front-panel chime LED between alarm, hourly chime and
// timer-expiry requesters. Each source has one pending slot holding a blink
// count. Jobs are served one at a time by fixed priority alarm > chime > timer.
// Each blink is one ON cycle followed by one OFF cycle. Every job is followed
// by GAP_CYCLES dark cycles.
// Optional feature macro: ALARM_PREEMPT_EN. When it is defined, a pending alarm
// interrupts a chime or timer job, and the interrupted source is re-queued
// with its remaining blink count.
module chime_indicator_arbiter #(
    parameter int TIMER_BLINKS = 3,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       alarm_req,
    input  logic [5:0] alarm_len,
    input  logic       chime_req,
    input  logic [4:0] chime_hour,
    input  logic       timer_req,
    input  logic       mute,
    output logic       chime_led,
    output logic       busy,
    output logic [1:0] grant,
    output logic [2:0] pend
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    localparam logic [5:0] TIMER_LEN = 6'(TIMER_BLINKS);
    localparam logic [2:0] GAP_LAST  = 3'(GAP_CYCLES - 1);

    state_t     state_q;
    logic [5:0] cnt_q;
    logic [2:0] gap_q;
    logic       led_q;
    logic       busy_q;
    logic [1:0] grant_q;
    logic [2:0] pend_q, pend_d;
    logic [5:0] alen_q, alen_d;
    logic [5:0] clen_q, clen_d;
    logic [5:0] tlen_q, tlen_d;

    logic [2:0] req_set;
    logic [5:0] chime_n;
    logic       can_grant;
    logic [2:0] pick_vec;
    logic [1:0] pick_code;
    logic [5:0] pick_len;
`ifdef ALARM_PREEMPT_EN
    logic       preempt;
    logic [5:0] remain;
`endif

    // Arbitration: choose the highest-priority pending source and its stored length
    always_comb begin
        pick_vec  = 3'b000;
        pick_code = 2'd0;
        pick_len  = 6'd0;
        if (pend_q[0]) begin
            pick_vec  = 3'b001;
            pick_code = 2'd1;
            pick_len  = alen_q;
        end else if (pend_q[1]) begin
            pick_vec  = 3'b010;
            pick_code = 2'd2;
            pick_len  = clen_q;
        end else if (pend_q[2]) begin
            pick_vec  = 3'b100;
            pick_code = 2'd3;
            pick_len  = tlen_q;
        end
        can_grant = (state_q == S_IDLE) && !mute && (pend_q != 3'b000);
    end

`ifdef ALARM_PREEMPT_EN
    // Preemption: a pending alarm cuts a chime/timer job short during its blink phase
    always_comb begin
        preempt = !mute && ((state_q == S_ON) || (state_q == S_OFF)) &&
                  (grant_q != 2'd1) && pend_q[0];
        // In ON the current blink is abandoned; in OFF it has already been shown
        remain  = (state_q == S_ON) ? cnt_q : (cnt_q - 6'd1);
    end
`endif

    // Pending slots: clear on grant, re-queue on preemption, then new requests win; mute clears all
    always_comb begin
        req_set = {timer_req, chime_req, alarm_req && (alarm_len != 6'd0)};
        chime_n = (chime_hour == 5'd0) ? 6'd24 : {1'b0, chime_hour};
        pend_d  = pend_q;
        alen_d  = alen_q;
        clen_d  = clen_q;
        tlen_d  = tlen_q;
        if (can_grant) begin
            pend_d = pend_d & ~pick_vec;
        end
`ifdef ALARM_PREEMPT_EN
        if (preempt && (remain != 6'd0)) begin
            if (grant_q == 2'd2) begin
                pend_d[1] = 1'b1;
                clen_d    = remain;
            end else if (grant_q == 2'd3) begin
                pend_d[2] = 1'b1;
                tlen_d    = remain;
            end
        end
`endif
        if (req_set[0]) begin
            pend_d[0] = 1'b1;
            alen_d    = alarm_len;
        end
        if (req_set[1]) begin
            pend_d[1] = 1'b1;
            clen_d    = chime_n;
        end
        if (req_set[2]) begin
            pend_d[2] = 1'b1;
            tlen_d    = TIMER_LEN;
        end
        if (mute) begin
            pend_d = 3'b000;
        end
    end

    // Job FSM with registered LED/busy/grant, plus the pending-slot registers
    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            gap_q   <= 3'd0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 2'd0;
            pend_q  <= 3'b000;
            alen_q  <= 6'd0;
            clen_q  <= 6'd0;
            tlen_q  <= 6'd0;
        end else begin
            pend_q <= pend_d;
            alen_q <= alen_d;
            clen_q <= clen_d;
            tlen_q <= tlen_d;
            if (mute && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                cnt_q   <= 6'd0;
                gap_q   <= 3'd0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                grant_q <= 2'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (can_grant) begin
                            state_q <= S_ON;
                            cnt_q   <= pick_len;
                            led_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            grant_q <= pick_code;
                        end
                    end
                    S_ON: begin
`ifdef ALARM_PREEMPT_EN
                        if (preempt) begin
                            state_q <= S_GAP;
                            gap_q   <= 3'd0;
                            led_q   <= 1'b0;
                        end else begin
                            state_q <= S_OFF;
                            led_q   <= 1'b0;
                        end
`else
                        state_q <= S_OFF;
                        led_q   <= 1'b0;
`endif
                    end
                    S_OFF: begin
`ifdef ALARM_PREEMPT_EN
                        if (preempt) begin
                            state_q <= S_GAP;
                            gap_q   <= 3'd0;
                            led_q   <= 1'b0;
                        end else if (cnt_q == 6'd1) begin
                            state_q <= S_GAP;
                            cnt_q   <= 6'd0;
                            gap_q   <= 3'd0;
                            led_q   <= 1'b0;
                        end else begin
                            state_q <= S_ON;
                            cnt_q   <= cnt_q - 6'd1;
                            led_q   <= 1'b1;
                        end
`else
                        if (cnt_q == 6'd1) begin
                            state_q <= S_GAP;
                            cnt_q   <= 6'd0;
                            gap_q   <= 3'd0;
                            led_q   <= 1'b0;
                        end else begin
                            state_q <= S_ON;
                            cnt_q   <= cnt_q - 6'd1;
                            led_q   <= 1'b1;
                        end
`endif
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                            gap_q   <= 3'd0;
                            busy_q  <= 1'b0;
                            grant_q <= 2'd0;
                        end else begin
                            gap_q <= gap_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        grant_q <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign chime_led = led_q;
    assign busy      = busy_q;
    assign grant     = grant_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_chime_indicator_arbiter.sv
// Bench for chime_indicator_arbiter: directed vector table, hand-written
// preemption and 24-blink sequences, and randomized traffic against a
// job-timeline reference model.
module tb_chime_indicator_arbiter;

    localparam int TB_TIMER = 3;
    localparam int TB_GAP   = 2;
`ifdef ALARM_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       CP;
    logic       CR;
    logic       alarm_req;
    logic [5:0] alarm_len;
    logic       chime_req;
    logic [4:0] chime_hour;
    logic       timer_req;
    logic       mute;
    logic       chime_led;
    logic       busy;
    logic [1:0] grant;
    logic [2:0] pend;

    chime_indicator_arbiter #(
        .TIMER_BLINKS(TB_TIMER),
        .GAP_CYCLES  (TB_GAP)
    ) dut (
        .CP        (CP),
        .CR        (CR),
        .alarm_req (alarm_req),
        .alarm_len (alarm_len),
        .chime_req (chime_req),
        .chime_hour(chime_hour),
        .timer_req (timer_req),
        .mute      (mute),
        .chime_led (chime_led),
        .busy      (busy),
        .grant     (grant),
        .pend      (pend)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one active job described by source, blink count and
    // elapsed cycles since grant; LED is lit on even offsets below 2N.
    bit       m_act;
    int       m_src;
    int       m_n;
    int       m_t;
    bit [2:0] m_pend;
    int       m_len[3];

    typedef struct {
        bit       cr;
        bit       ar;
        bit [5:0] al;
        bit       cq;
        bit [4:0] ch;
        bit       tq;
        bit       mu;
        bit       led;
        bit       bsy;
        bit [1:0] gr;
        bit [2:0] pd;
    } vec_t;

    vec_t tv[45];

    function automatic vec_t v(bit cr, bit ar, bit [5:0] al, bit cq, bit [4:0] ch,
                               bit tq, bit mu, bit led, bit bsy, bit [1:0] gr, bit [2:0] pd);
        vec_t r;
        r.cr = cr; r.ar = ar; r.al = al; r.cq = cq; r.ch = ch; r.tq = tq; r.mu = mu;
        r.led = led; r.bsy = bsy; r.gr = gr; r.pd = pd;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit [2:0] np;
        int       nl[3];
        int       rem;
        if (CR) begin
            m_act = 0; m_src = 0; m_n = 0; m_t = 0; m_pend = 3'b000;
            m_len = '{0, 0, 0};
            return;
        end
        np = m_pend;
        nl = m_len;
        if (m_act) begin
            if (mute) begin
                m_act = 0;
            end else if (PRE && m_src != 0 && m_t < 2 * m_n && m_pend[0]) begin
                rem = m_n - (m_t + 1) / 2;
                if (rem > 0) begin
                    np[m_src] = 1'b1;
                    nl[m_src] = rem;
                end
                m_t = 2 * m_n;
            end else begin
                m_t++;
                if (m_t >= 2 * m_n + TB_GAP) m_act = 0;
            end
        end else if (!mute && m_pend != 3'b000) begin
            for (int i = 2; i >= 0; i--) if (m_pend[i]) m_src = i;
            np[m_src] = 1'b0;
            m_n = m_len[m_src];
            m_t = 0;
            m_act = 1;
        end
        if (mute) begin
            np = 3'b000;
        end else begin
            if (alarm_req && alarm_len != 0) begin np[0] = 1'b1; nl[0] = int'(alarm_len); end
            if (chime_req) begin np[1] = 1'b1; nl[1] = (chime_hour == 0) ? 24 : int'(chime_hour); end
            if (timer_req) begin np[2] = 1'b1; nl[2] = TB_TIMER; end
        end
        m_pend = np;
        m_len  = nl;
    endtask

    task automatic step();
        @(posedge CP);
        model_edge();
        #1;
    endtask

    task automatic step_m(string tag);
        bit exp_led;
        step();
        exp_led = m_act && (m_t < 2 * m_n) && (m_t % 2 == 0);
        check({tag, " led"},   chime_led, exp_led);
        check({tag, " busy"},  busy,      m_act);
        check({tag, " grant"}, grant,     m_act ? m_src + 1 : 0);
        check({tag, " pend"},  pend,      m_pend);
    endtask

    task automatic clear_inputs();
        CR = 0; alarm_req = 0; alarm_len = 0; chime_req = 0; chime_hour = 0;
        timer_req = 0; mute = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        CR = 1;
        step();
        CR = 0;
    endtask

    int pulses[$];
    int exp_a[$];

    task automatic step_rec();
        step_m("preempt_seq");
        if (chime_led) pulses.push_back(int'(grant));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        int n_led;
        int last_led;

        clear_inputs();
        CR = 1;

        tv[0]  = v(1,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[1]  = v(0,0,0,1,3,0,0, 0,0,0,3'b010);
        tv[2]  = v(0,0,0,0,0,0,0, 1,1,2,3'b000);
        tv[3]  = v(0,0,0,0,0,0,0, 0,1,2,3'b000);
        tv[4]  = v(0,0,0,0,0,0,0, 1,1,2,3'b000);
        tv[5]  = v(0,0,0,0,0,0,0, 0,1,2,3'b000);
        tv[6]  = v(0,0,0,0,0,0,0, 1,1,2,3'b000);
        tv[7]  = v(0,0,0,0,0,0,0, 0,1,2,3'b000);
        tv[8]  = v(0,0,0,0,0,0,0, 0,1,2,3'b000);
        tv[9]  = v(0,0,0,0,0,0,0, 0,1,2,3'b000);
        tv[10] = v(0,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[11] = v(0,1,2,1,1,1,0, 0,0,0,3'b111);
        tv[12] = v(0,0,0,0,0,0,0, 1,1,1,3'b110);
        tv[13] = v(0,0,0,0,0,0,0, 0,1,1,3'b110);
        tv[14] = v(0,0,0,0,0,0,0, 1,1,1,3'b110);
        tv[15] = v(0,0,0,0,0,0,0, 0,1,1,3'b110);
        tv[16] = v(0,0,0,0,0,0,0, 0,1,1,3'b110);
        tv[17] = v(0,0,0,0,0,0,0, 0,1,1,3'b110);
        tv[18] = v(0,0,0,0,0,0,0, 0,0,0,3'b110);
        tv[19] = v(0,0,0,0,0,0,0, 1,1,2,3'b100);
        tv[20] = v(0,0,0,0,0,0,0, 0,1,2,3'b100);
        tv[21] = v(0,0,0,0,0,0,0, 0,1,2,3'b100);
        tv[22] = v(0,0,0,0,0,0,0, 0,1,2,3'b100);
        tv[23] = v(0,0,0,0,0,0,0, 0,0,0,3'b100);
        tv[24] = v(0,0,0,0,0,0,0, 1,1,3,3'b000);
        tv[25] = v(0,0,0,0,0,0,0, 0,1,3,3'b000);
        tv[26] = v(0,0,0,0,0,0,0, 1,1,3,3'b000);
        tv[27] = v(0,0,0,0,0,0,0, 0,1,3,3'b000);
        tv[28] = v(0,0,0,0,0,0,0, 1,1,3,3'b000);
        tv[29] = v(0,0,0,0,0,0,0, 0,1,3,3'b000);
        tv[30] = v(0,0,0,0,0,0,0, 0,1,3,3'b000);
        tv[31] = v(0,0,0,0,0,0,0, 0,1,3,3'b000);
        tv[32] = v(0,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[33] = v(0,1,3,0,0,1,0, 0,0,0,3'b101);
        tv[34] = v(0,1,3,0,0,0,0, 1,1,1,3'b101);
        tv[35] = v(0,0,0,0,0,0,0, 0,1,1,3'b101);
        tv[36] = v(1,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[37] = v(0,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[38] = v(0,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[39] = v(0,0,0,1,5,0,0, 0,0,0,3'b010);
        tv[40] = v(0,0,0,0,0,0,0, 1,1,2,3'b000);
        tv[41] = v(0,0,0,0,0,1,1, 0,0,0,3'b000);
        tv[42] = v(0,1,4,0,0,0,1, 0,0,0,3'b000);
        tv[43] = v(0,0,0,0,0,0,0, 0,0,0,3'b000);
        tv[44] = v(0,0,0,0,0,0,0, 0,0,0,3'b000);

        // Directed vector table
        for (int i = 0; i < 45; i++) begin
            CR = tv[i].cr; alarm_req = tv[i].ar; alarm_len = tv[i].al;
            chime_req = tv[i].cq; chime_hour = tv[i].ch; timer_req = tv[i].tq; mute = tv[i].mu;
            step();
            check($sformatf("vec%0d led", i),   chime_led, tv[i].led);
            check($sformatf("vec%0d busy", i),  busy,      tv[i].bsy);
            check($sformatf("vec%0d grant", i), grant,     tv[i].gr);
            check($sformatf("vec%0d pend", i),  pend,      tv[i].pd);
        end
        clear_inputs();

        // Timer job with alarm arriving for the second ON
        apply_reset();
        pulses.delete();
        timer_req = 1;
        step_rec();
        timer_req = 0;
        step_rec();
        step_rec();
        alarm_req = 1; alarm_len = 1;
        step_rec();
        alarm_req = 0; alarm_len = 0;
        for (int k = 0; k < 80 && !(busy == 1'b0 && pend == 3'b000); k++) step_rec();
        check("preempt_seq settled busy", busy, 0);
        if (PRE) exp_a = '{3, 3, 1, 3, 3};
        else     exp_a = '{3, 3, 3, 1};
        check("preempt_seq pulse count", pulses.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < pulses.size(); k++)
            check($sformatf("preempt_seq pulse%0d grant", k), pulses[k], exp_a[k]);

        // Hour 0 gives 24 blinks, then GAP, then IDLE
        apply_reset();
        chime_req = 1; chime_hour = 0;
        step_m("hour0 req");
        chime_req = 0;
        n_busy = 0; n_led = 0; last_led = -1;
        for (int k = 0; k < 120; k++) begin
            step_m("hour0");
            if (!busy) break;
            if (chime_led) begin
                n_led++;
                last_led = n_busy;
            end
            n_busy++;
        end
        check("hour0 blinks", n_led, 24);
        check("hour0 busy cycles", n_busy, 2 * 24 + TB_GAP);
        check("hour0 dark tail", n_busy - 1 - last_led, 1 + TB_GAP);

        // Randomized traffic against the model
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            CR         = ($urandom % 500) == 0;
            alarm_req  = ($urandom % 14) == 0;
            alarm_len  = 6'($urandom_range(0, 6));
            chime_req  = ($urandom % 12) == 0;
            chime_hour = 5'($urandom_range(0, 23));
            timer_req  = ($urandom % 12) == 0;
            mute       = ($urandom % 60) == 0;
            step_m($sformatf("rand%0d", c));
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
